// File: rtl/lifo_stack.sv
// Parametrised synchronous LIFO stack with registered pop output and replace-top on push+pop.
// Define LIFO_ERR_EN to enable the sticky overflow/underflow flags (cleared by err_clr).
module lifo_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp;
    logic [CW-1:0]    sp_next;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    wr_addr;
    logic             wr_en;
    logic             out_en;
    logic [WIDTH-1:0] out_data;
    logic             ovf_evt;
    logic             udf_evt;
    logic             is_full;
    logic             is_empty;

    assign is_empty = (sp == '0);
    assign is_full  = (sp == DEPTH_C);
    assign top_idx  = AW'(sp - CW'(1));
    assign wr_idx   = AW'(sp);

    assign count = sp;
    assign full  = is_full;
    assign empty = is_empty;

    // top_idx wraps when empty, so the array read is masked rather than trusted
    always_comb begin
        top = '0;
        if (!is_empty) begin
            top = mem[top_idx];
        end
    end

    always_comb begin
        sp_next  = sp;
        wr_en    = 1'b0;
        wr_addr  = wr_idx;
        out_en   = 1'b0;
        out_data = din;
        ovf_evt  = 1'b0;
        udf_evt  = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (!is_full) begin
                    wr_en   = 1'b1;
                    sp_next = sp + CW'(1);
                end else begin
                    ovf_evt = 1'b1;
                end
            end
            2'b01: begin
                if (!is_empty) begin
                    out_en   = 1'b1;
                    out_data = mem[top_idx];
                    sp_next  = sp - CW'(1);
                end else begin
                    udf_evt = 1'b1;
                end
            end
            2'b11: begin
                // Empty stack passes din straight through; otherwise the top is swapped.
                out_en = 1'b1;
                if (!is_empty) begin
                    out_data = mem[top_idx];
                    wr_en    = 1'b1;
                    wr_addr  = top_idx;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_addr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            sp         <= sp_next;
            dout_valid <= out_en;
            if (out_en) begin
                dout <= out_data;
            end
        end
    end

`ifdef LIFO_ERR_EN
    // A new error on the same edge as err_clr keeps its flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (udf_evt) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`else
    logic err_unused;
    assign err_unused = err_clr ^ ovf_evt ^ udf_evt;
    assign overflow   = 1'b0;
    assign underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: directed test-plan sequences then randomized
// traffic, all compared against a queue-based reference model.
module tb_lifo_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;
    logic             err_clr;

    lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .top        (top),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .underflow  (underflow),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_vld;
    logic             m_ovf;
    logic             m_udf;

`ifdef LIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic pu, input logic po,
                                input logic [WIDTH-1:0] d, input logic clr);
        logic ovf_e;
        logic udf_e;
        ovf_e = 1'b0;
        udf_e = 1'b0;
        if (r) begin
            q.delete();
            m_dout = '0;
            m_vld  = 1'b0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            return;
        end
        m_vld = 1'b0;
        if (pu && po) begin
            m_vld = 1'b1;
            if (q.size() == 0) begin
                m_dout = d;
            end else begin
                m_dout = q[q.size() - 1];
                q[q.size() - 1] = d;
            end
        end else if (pu) begin
            if (q.size() < DEPTH) q.push_back(d);
            else ovf_e = 1'b1;
        end else if (po) begin
            if (q.size() > 0) begin
                m_dout = q.pop_back();
                m_vld  = 1'b1;
            end else begin
                udf_e = 1'b1;
            end
        end
        if (ERR_EN) begin
            if (ovf_e) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            if (udf_e) m_udf = 1'b1;
            else if (clr) m_udf = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic [WIDTH-1:0] exp_top;
        exp_top = (q.size() > 0) ? q[q.size() - 1] : '0;
        check("dout",       32'(dout),       32'(m_dout));
        check("dout_valid", 32'(dout_valid), 32'(m_vld));
        check("count",      32'(count),      32'(q.size()));
        check("full",       32'(full),       32'(q.size() == DEPTH));
        check("empty",      32'(empty),      32'(q.size() == 0));
        check("top",        32'(top),        32'(exp_top));
        check("overflow",   32'(overflow),   32'(m_ovf));
        check("underflow",  32'(underflow),  32'(m_udf));
    endtask

    // Apply one cycle of inputs, advance the clock, then compare 1 time unit later.
    task automatic step(input logic r, input logic pu, input logic po,
                        input logic [WIDTH-1:0] d, input logic clr);
        reset   = r;
        push    = pu;
        pop     = po;
        din     = d;
        err_clr = clr;
        @(posedge clk);
        model_update(r, pu, po, d, clr);
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; din = '0; err_clr = 1'b0;
        m_dout = '0; m_vld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;

        // Reset state
        step(1, 0, 0, 8'h00, 0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);

        // Fill then drain
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 0, 8'(i), 0);
            check("fill_count", 32'(count), 32'(i));
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_top",  32'(top),  32'h04);

        // Overflow and clear
        step(0, 1, 0, 8'h05, 0);
        check("ovf_top",   32'(top),      32'h04);
        check("ovf_count", 32'(count),    32'd4);
        check("ovf_flag",  32'(overflow), 32'(ERR_EN));
        // Replace-top at full
        step(0, 1, 1, 8'h0D, 0);
        check("rep_full_dout", 32'(dout), 32'h04);
        check("rep_full_full", 32'(full), 32'd1);
        step(0, 0, 0, 8'h00, 1);
        check("ovf_clr", 32'(overflow), 32'd0);

        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 8'h00, 0);
            check("drain_dout", 32'(dout), (i == 0) ? 32'h0D : 32'(3 - i + 1));
            check("drain_vld",  32'(dout_valid), 32'd1);
        end
        check("drain_empty", 32'(empty), 32'd1);

        // Underflow: dout held at 01
        step(0, 0, 1, 8'h00, 0);
        check("udf_vld",  32'(dout_valid), 32'd0);
        check("udf_dout", 32'(dout),       32'h01);
        check("udf_flag", 32'(underflow),  32'(ERR_EN));
        step(0, 0, 0, 8'h00, 1);

        // Replace top on 0A,0B
        step(0, 1, 0, 8'h0A, 0);
        step(0, 1, 0, 8'h0B, 0);
        step(0, 1, 1, 8'h0C, 0);
        check("rep_dout",  32'(dout),  32'h0B);
        check("rep_count", 32'(count), 32'd2);
        check("rep_top",   32'(top),   32'h0C);

        // Pass-through on empty
        step(1, 0, 0, 8'h00, 0);
        step(0, 1, 1, 8'h55, 0);
        check("pt_dout",  32'(dout),       32'h55);
        check("pt_vld",   32'(dout_valid), 32'd1);
        check("pt_count", 32'(count),      32'd0);
        check("pt_flags", 32'({overflow, underflow}), 32'd0);

        // Reset mid-operation while pushing
        step(0, 1, 0, 8'h01, 0);
        step(0, 1, 0, 8'h02, 0);
        step(0, 1, 0, 8'h03, 0);
        step(1, 1, 0, 8'h04, 0);
        check("mrst_count", 32'(count), 32'd0);
        check("mrst_dout",  32'(dout),  32'd0);
        step(0, 0, 1, 8'h00, 0);
        check("mrst_pop_vld", 32'(dout_valid), 32'd0);
        check("mrst_udf",     32'(underflow),  32'(ERR_EN));

        // Randomized traffic with a drifting push/pop bias to reach full and empty often
        for (int i = 0; i < 1500; i++) begin
            int bias;
            int r;
            logic pu;
            logic po;
            bias = ((i / 50) % 2 == 0) ? 70 : 30;
            r  = $urandom_range(0, 99);
            pu = (r < bias);
            po = ($urandom_range(0, 99) < (100 - bias));
            step(($urandom_range(0, 99) == 0), pu, po, 8'($urandom),
                 ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
